// File: rtl/lcd_ddram_reader.sv
// Reads both DDRAM lines and the busy flag / address counter back from an
// HD44780-compatible 2x16 LCD. Owns the LCD bus while oBusy is high.
module lcd_ddram_reader #(
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned EN_HIGH_CYC  = 24,
  parameter int unsigned EN_LOW_CYC   = 30,
  parameter int unsigned BF_MAX_POLLS = 4096
) (
  input  logic         iCLK_50,
  input  logic         iRST_N,
  input  logic         iStart,
  input  logic [7:0]   iLCD_D,
  output logic [7:0]   oLCD_D,
  output logic         oLCD_D_OE,
  output logic         oLCD_RS,
  output logic         oLCD_RW,
  output logic         oLCD_EN,
  output logic         oBusy,
  output logic         oDone,
  output logic         oTimeout,
  output logic [6:0]   oAC,
  output logic [127:0] oString0,
  output logic [127:0] oString1
);

  localparam int unsigned CNT_MAX01 = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
  localparam int unsigned CNT_MAX   = (CNT_MAX01 > EN_LOW_CYC) ? CNT_MAX01 : EN_LOW_CYC;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned POLL_W    = $clog2(BF_MAX_POLLS + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_POLL    = 3'd1;
  localparam logic [2:0] S_SETADDR = 3'd2;
  localparam logic [2:0] S_READ    = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;
  localparam logic [2:0] S_TIMEOUT = 3'd5;

  // TURN is a one-cycle bus-direction change inserted only when the next
  // access reverses direction, so OE and RW never overlap.
  localparam logic [1:0] P_TURN  = 2'd0;
  localparam logic [1:0] P_SETUP = 2'd1;
  localparam logic [1:0] P_EN_HI = 2'd2;
  localparam logic [1:0] P_EN_LO = 2'd3;

  logic [2:0]        r_state, w_state;
  logic [1:0]        r_ph, w_ph;
  logic [CNT_W-1:0]  r_cnt, w_cnt, w_lim;
  logic [POLL_W-1:0] r_polls, w_polls;
  logic [3:0]        r_col, w_col;
  logic              r_line, w_line;
  logic              r_addr_done, w_addr_done;
  logic              r_bf, w_bf;
  logic [127:0]      r_shadow, w_shadow;
  logic              r_en, w_en, r_rw, w_rw, r_rs, w_rs, r_oe, w_oe;
  logic [7:0]        r_d, w_d;
  logic              r_busy, w_busy, r_done, w_done, r_timeout, w_timeout;
  logic [6:0]        r_ac, w_ac;
  logic [127:0]      r_str0, w_str0, r_str1, w_str1;

  // State and registered outputs
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= S_IDLE;
      r_ph        <= P_SETUP;
      r_cnt       <= '0;
      r_polls     <= '0;
      r_col       <= '0;
      r_line      <= 1'b0;
      r_addr_done <= 1'b0;
      r_bf        <= 1'b0;
      r_shadow    <= '0;
      r_en        <= 1'b0;
      r_rw        <= 1'b1;
      r_rs        <= 1'b0;
      r_oe        <= 1'b0;
      r_d         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_ac        <= '0;
      r_str0      <= '0;
      r_str1      <= '0;
    end else begin
      r_state     <= w_state;
      r_ph        <= w_ph;
      r_cnt       <= w_cnt;
      r_polls     <= w_polls;
      r_col       <= w_col;
      r_line      <= w_line;
      r_addr_done <= w_addr_done;
      r_bf        <= w_bf;
      r_shadow    <= w_shadow;
      r_en        <= w_en;
      r_rw        <= w_rw;
      r_rs        <= w_rs;
      r_oe        <= w_oe;
      r_d         <= w_d;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_timeout   <= w_timeout;
      r_ac        <= w_ac;
      r_str0      <= w_str0;
      r_str1      <= w_str1;
    end
  end

  // Top FSM and access micro-sequencer next-state logic
  always_comb begin
    w_state     = r_state;
    w_ph        = r_ph;
    w_cnt       = r_cnt;
    w_polls     = r_polls;
    w_col       = r_col;
    w_line      = r_line;
    w_addr_done = r_addr_done;
    w_bf        = r_bf;
    w_shadow    = r_shadow;
    w_en        = r_en;
    w_rw        = r_rw;
    w_rs        = r_rs;
    w_oe        = r_oe;
    w_d         = r_d;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_timeout   = r_timeout;
    w_ac        = r_ac;
    w_str0      = r_str0;
    w_str1      = r_str1;

    case (r_ph)
      P_SETUP: w_lim = CNT_W'(SETUP_CYC - 1);
      P_EN_HI: w_lim = CNT_W'(EN_HIGH_CYC - 1);
      default: w_lim = CNT_W'(EN_LOW_CYC - 1);
    endcase

    case (r_state)
      S_IDLE: begin
        if (iStart) begin
          w_timeout   = 1'b0;
          w_busy      = 1'b1;
          w_line      = 1'b0;
          w_addr_done = 1'b0;
          w_polls     = '0;
          w_state     = S_POLL;
          w_ph        = P_SETUP;
          w_cnt       = '0;
          w_rs        = 1'b0;
          w_rw        = 1'b1;
          w_oe        = 1'b0;
          w_d         = '0;
        end
      end
      S_FINISH, S_TIMEOUT: w_state = S_IDLE;
      default: begin
        case (r_ph)
          P_TURN: begin
            w_ph  = P_SETUP;
            w_cnt = '0;
            if (r_state == S_SETADDR) begin
              w_oe = 1'b1;
            end else begin
              w_rw = 1'b1;
              w_rs = (r_state == S_READ);
            end
          end
          P_SETUP: begin
            if (r_cnt == w_lim) begin
              w_ph  = P_EN_HI;
              w_cnt = '0;
              w_en  = 1'b1;
            end else begin
              w_cnt = r_cnt + CNT_W'(1);
            end
          end
          P_EN_HI: begin
            if (r_cnt == w_lim) begin
              w_ph  = P_EN_LO;
              w_cnt = '0;
              w_en  = 1'b0;
              if (r_state == S_POLL) begin
                w_ac = iLCD_D[6:0];
                w_bf = iLCD_D[7];
              end else if (r_state == S_READ) begin
                w_shadow[{~r_col, 3'b000} +: 8] = iLCD_D;
              end
            end else begin
              w_cnt = r_cnt + CNT_W'(1);
            end
          end
          default: begin
            if (r_cnt != w_lim) begin
              w_cnt = r_cnt + CNT_W'(1);
            end else begin
              w_cnt = '0;
              w_ph  = P_SETUP;
              case (r_state)
                S_POLL: begin
                  if (!r_bf) begin
                    if (r_addr_done) begin
                      w_state = S_READ;
                      w_col   = '0;
                      w_rs    = 1'b1;
                    end else begin
                      w_state = S_SETADDR;
                      w_ph    = P_TURN;
                      w_rw    = 1'b0;
                      w_rs    = 1'b0;
                      w_oe    = 1'b0;
                      w_d     = r_line ? 8'hC0 : 8'h80;
                    end
                  end else begin
                    w_polls = r_polls + POLL_W'(1);
                    if (w_polls == POLL_W'(BF_MAX_POLLS)) begin
                      w_state   = S_TIMEOUT;
                      w_timeout = 1'b1;
                      w_busy    = 1'b0;
                      w_done    = 1'b1;
                      w_rw      = 1'b1;
                      w_oe      = 1'b0;
                    end
                  end
                end
                S_SETADDR: begin
                  w_state     = S_POLL;
                  w_polls     = '0;
                  w_addr_done = 1'b1;
                  w_ph        = P_TURN;
                  w_oe        = 1'b0;
                end
                default: begin
                  if (r_col == 4'd15) begin
                    if (!r_line) begin
                      w_str0      = r_shadow;
                      w_line      = 1'b1;
                      w_addr_done = 1'b0;
                      w_state     = S_POLL;
                      w_polls     = '0;
                      w_rs        = 1'b0;
                    end else begin
                      w_str1  = r_shadow;
                      w_state = S_FINISH;
                      w_busy  = 1'b0;
                      w_done  = 1'b1;
                    end
                  end else begin
                    w_col = r_col + 4'd1;
                  end
                end
              endcase
            end
          end
        endcase
      end
    endcase
  end

  assign oLCD_D    = r_d;
  assign oLCD_D_OE = r_oe;
  assign oLCD_RS   = r_rs;
  assign oLCD_RW   = r_rw;
  assign oLCD_EN   = r_en;
  assign oBusy     = r_busy;
  assign oDone     = r_done;
  assign oTimeout  = r_timeout;
  assign oAC       = r_ac;
  assign oString0  = r_str0;
  assign oString1  = r_str1;

endmodule

// File: tb/tb_lcd_ddram_reader.sv
// Bench for lcd_ddram_reader: LCD model, bus protocol monitor, scenario table
// and hand-written reset / repeated-start sequences.
module tb_lcd_ddram_reader;

  // Poll limit reduced so the permanent-busy case stays short.
  localparam int unsigned POLL_LIMIT = 128;

  logic         iCLK_50 = 1'b0;
  logic         iRST_N  = 1'b0;
  logic         iStart  = 1'b0;
  logic [7:0]   iLCD_D;
  logic [7:0]   oLCD_D;
  logic         oLCD_D_OE, oLCD_RS, oLCD_RW, oLCD_EN;
  logic         oBusy, oDone, oTimeout;
  logic [6:0]   oAC;
  logic [127:0] oString0, oString1;

  always #10 iCLK_50 = ~iCLK_50;

  lcd_ddram_reader #(.BF_MAX_POLLS(POLL_LIMIT)) dut (
    .iCLK_50(iCLK_50), .iRST_N(iRST_N), .iStart(iStart), .iLCD_D(iLCD_D),
    .oLCD_D(oLCD_D), .oLCD_D_OE(oLCD_D_OE), .oLCD_RS(oLCD_RS), .oLCD_RW(oLCD_RW),
    .oLCD_EN(oLCD_EN), .oBusy(oBusy), .oDone(oDone), .oTimeout(oTimeout),
    .oAC(oAC), .oString0(oString0), .oString1(oString1)
  );

  // LCD model: mode 0 BF never set, 1 BF set for 100 polls before each
  // address write (AC reads 7'h10 when ready), 2 BF stuck at 1.
  logic [7:0] mem [0:127];
  int         mode = 0;
  logic [6:0] m_ac = 7'd0;
  int         bf_left = 0, m_polls = 0, m_rd = 0, m_wr = 0;
  logic [7:0] wr_log [0:3];
  logic       en_q = 1'b0;
  logic       m_bf;

  assign m_bf   = (mode == 2) || (mode == 1 && bf_left > 0);
  assign iLCD_D = (oLCD_EN && oLCD_RW) ?
                  (oLCD_RS ? mem[m_ac] : {m_bf, (mode == 1 && !m_bf) ? 7'h10 : m_ac}) : 8'h00;

  // Model updates once per completed access (EN falling)
  always @(posedge iCLK_50) begin
    en_q <= oLCD_EN;
    if (!iRST_N) begin
      en_q <= 1'b0;
    end else if (iStart && !oBusy && !oDone) begin
      m_polls <= 0;
      m_rd    <= 0;
      m_wr    <= 0;
      bf_left <= (mode == 1) ? 100 : 0;
    end else if (en_q && !oLCD_EN) begin
      case ({oLCD_RS, oLCD_RW})
        2'b01: begin
          m_polls <= m_polls + 1;
          if (bf_left > 0) bf_left <= bf_left - 1;
        end
        2'b00: begin
          m_ac <= oLCD_D[6:0];
          if (m_wr < 4) wr_log[m_wr[1:0]] <= oLCD_D;
          m_wr    <= m_wr + 1;
          bf_left <= 0;
        end
        2'b11: begin
          m_ac <= m_ac + 7'd1;
          m_rd <= m_rd + 1;
          if (mode == 1) bf_left <= 100;
        end
        default: ;
      endcase
    end
  end

  // Bus protocol monitor: tallies timing and direction-rule violations
  logic prev_rs = 1'b0, prev_rw = 1'b1, prev_oe = 1'b0, prev_en = 1'b0;
  int   hi_len = 0, low_len = 1000, sc = 1000;
  logic rules_flag = 1'b0;
  int   c_acc = 0, c_bad_hi = 0, c_bad_lo = 0, c_bad_setup = 0, c_bad_rules = 0, last_hi = 0;
  logic chg, rules_now;
  int   lo_next, sc_next;

  assign chg       = ({oLCD_RS, oLCD_RW} != {prev_rs, prev_rw});
  assign lo_next   = oLCD_EN ? low_len : ((low_len < 1000) ? low_len + 1 : low_len);
  assign sc_next   = chg ? 0 : ((sc < 1000) ? sc + 1 : sc);
  assign rules_now = (oLCD_D_OE && oLCD_RW) || (oLCD_RW && !prev_rw && prev_oe) ||
                     (oLCD_D_OE && !prev_oe && prev_rw) || (chg && (oLCD_EN || lo_next <= 30));

  always @(negedge iCLK_50) begin
    if (!iRST_N) begin
      prev_rs <= 1'b0; prev_rw <= 1'b1; prev_oe <= 1'b0; prev_en <= 1'b0;
      hi_len <= 0; low_len <= 1000; sc <= 1000; rules_flag <= 1'b0;
    end else begin
      prev_rs <= oLCD_RS; prev_rw <= oLCD_RW; prev_oe <= oLCD_D_OE; prev_en <= oLCD_EN;
      sc <= sc_next;
      if (oLCD_EN && !prev_en) begin
        c_acc <= c_acc + 1;
        if (sc_next < 2) c_bad_setup <= c_bad_setup + 1;
        if (low_len < 30) c_bad_lo <= c_bad_lo + 1;
        if (rules_flag || rules_now) c_bad_rules <= c_bad_rules + 1;
        rules_flag <= 1'b0;
        hi_len <= 1;
      end else begin
        rules_flag <= rules_flag | rules_now;
        if (oLCD_EN) hi_len <= hi_len + 1;
      end
      if (!oLCD_EN && prev_en) begin
        if (hi_len != 24) begin
          c_bad_hi <= c_bad_hi + 1;
          last_hi  <= hi_len;
        end
        low_len <= 1;
      end else begin
        low_len <= lo_next;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_le(input string nm, input int act, input int lim);
    checks++;
    if (act > lim) begin
      errors++;
      $display("FAIL %s: got %0d required <= %0d", nm, act, lim);
    end
  endtask

  task automatic load(input logic [127:0] a, input logic [127:0] b);
    for (int k = 0; k < 128; k++) mem[k] = 8'h20;
    for (int c = 0; c < 16; c++) begin
      mem[c]      = a[8*(15-c) +: 8];
      mem[64 + c] = b[8*(15-c) +: 8];
    end
  endtask

  task automatic pulse_start();
    @(negedge iCLK_50);
    iStart = 1'b1;
    @(negedge iCLK_50);
    iStart = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int lat, output bit ok);
    lat = 0;
    while (!oDone && lat < max_cyc) begin
      @(negedge iCLK_50);
      lat++;
    end
    ok = oDone;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_wait: got no oDone after %0d cycles required one", lat);
    end
  endtask

  typedef struct {
    int           mode;
    logic [127:0] l0, l1, exp_s0, exp_s1;
    logic         exp_to;
    logic [6:0]   exp_ac;
    int           exp_polls, exp_wr, max_lat;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int lat, d0, a0, h0, lo0, s0, r0, n;
    bit ok;

    vecs[0] = '{0, "HELLO DE2-70 LCD", "0123456789ABCDEF", "HELLO DE2-70 LCD", "0123456789ABCDEF", 1'b0, 7'h40, 4,   2, 2140};
    vecs[1] = '{1, "DDRAM readback 1", "second line test", "DDRAM readback 1", "second line test", 1'b0, 7'h10, 204, 2, 20000};
    vecs[2] = '{2, "XXXXXXXXXXXXXXXX", "YYYYYYYYYYYYYYYY", "DDRAM readback 1", "second line test", 1'b1, 7'h50, 128, 0, 20000};
    vecs[3] = '{0, "ABCDEFGHIJKLMNOP", "qrstuvwxyz012345", "ABCDEFGHIJKLMNOP", "qrstuvwxyz012345", 1'b0, 7'h40, 4,   2, 2140};

    // Reset values
    repeat (3) @(negedge iCLK_50);
    chk("rst_en", oLCD_EN, 1'b0);
    chk("rst_rw", oLCD_RW, 1'b1);
    chk("rst_rs", oLCD_RS, 1'b0);
    chk("rst_d", oLCD_D, 8'h00);
    chk("rst_oe", oLCD_D_OE, 1'b0);
    chk("rst_busy", oBusy, 1'b0);
    chk("rst_done", oDone, 1'b0);
    chk("rst_to", oTimeout, 1'b0);
    chk("rst_ac", oAC, 7'h00);
    chk("rst_s0", oString0, 128'h0);
    chk("rst_s1", oString1, 128'h0);
    iRST_N = 1'b1;
    repeat (2) @(negedge iCLK_50);

    for (int i = 0; i < 4; i++) begin
      mode = vecs[i].mode;
      load(vecs[i].l0, vecs[i].l1);
      d0 = dut_done_cnt; a0 = c_acc; h0 = c_bad_hi; lo0 = c_bad_lo; s0 = c_bad_setup; r0 = c_bad_rules;
      pulse_start();
      chk("start_busy", oBusy, 1'b1);
      chk("start_to_clr", oTimeout, 1'b0);
      wait_done(vecs[i].max_lat, lat, ok);
      chk_le("latency", lat, vecs[i].max_lat);
      chk("end_busy", oBusy, 1'b0);
      chk("end_to", oTimeout, vecs[i].exp_to);
      chk("end_s0", oString0, vecs[i].exp_s0);
      chk("end_s1", oString1, vecs[i].exp_s1);
      chk("end_ac", oAC, vecs[i].exp_ac);
      chk("rel_rw", oLCD_RW, 1'b1);
      chk("rel_oe", oLCD_D_OE, 1'b0);
      chk("rel_en", oLCD_EN, 1'b0);
      repeat (5) @(negedge iCLK_50);
      chk("done_pulses", dut_done_cnt - d0, 1);
      chk("done_low", oDone, 1'b0);
      chk("polls", m_polls, vecs[i].exp_polls);
      chk("writes", m_wr, vecs[i].exp_wr);
      if (vecs[i].exp_wr == 2) begin
        chk("instr0", wr_log[0], 8'h80);
        chk("instr1", wr_log[1], 8'hC0);
      end
      chk("accesses", c_acc - a0, vecs[i].exp_polls + vecs[i].exp_wr + (vecs[i].exp_to ? 0 : 32));
      chk("en_high_bad", c_bad_hi - h0, 0);
      if (c_bad_hi != h0) $display("  last EN high width %0d", last_hi);
      chk("en_low_bad", c_bad_lo - lo0, 0);
      chk("setup_bad", c_bad_setup - s0, 0);
      chk("bus_rules_bad", c_bad_rules - r0, 0);
      chk("bus_rules_tail", rules_flag, 1'b0);
    end

    // Reset in the middle of the 7th read of line 2
    mode = 0;
    load("RESET TEST LINE1", "reset test line2");
    pulse_start();
    n = 0;
    while (!(m_rd == 22 && oLCD_EN) && n < 5000) begin
      @(negedge iCLK_50);
      n++;
    end
    chk_le("reach_read23", n, 4999);
    #3 iRST_N = 1'b0;
    #1;
    chk("mid_rst_en", oLCD_EN, 1'b0);
    chk("mid_rst_rw", oLCD_RW, 1'b1);
    chk("mid_rst_rs", oLCD_RS, 1'b0);
    chk("mid_rst_d", oLCD_D, 8'h00);
    chk("mid_rst_oe", oLCD_D_OE, 1'b0);
    chk("mid_rst_busy", oBusy, 1'b0);
    chk("mid_rst_done", oDone, 1'b0);
    chk("mid_rst_ac", oAC, 7'h00);
    chk("mid_rst_s0", oString0, 128'h0);
    chk("mid_rst_s1", oString1, 128'h0);
    repeat (2) @(negedge iCLK_50);
    iRST_N = 1'b1;
    repeat (2) @(negedge iCLK_50);
    d0 = dut_done_cnt; r0 = c_bad_rules; h0 = c_bad_hi;
    pulse_start();
    wait_done(2140, lat, ok);
    chk("post_rst_s0", oString0, "RESET TEST LINE1");
    chk("post_rst_s1", oString1, "reset test line2");
    chk("post_rst_to", oTimeout, 1'b0);
    repeat (3) @(negedge iCLK_50);
    chk("post_rst_done", dut_done_cnt - d0, 1);
    chk("post_rst_rules", c_bad_rules - r0, 0);
    chk("post_rst_hi", c_bad_hi - h0, 0);

    // Repeated iStart while busy and on the oDone cycle
    load("repeat start L1 ", "repeat start L2 ");
    d0 = dut_done_cnt;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      repeat (400) @(negedge iCLK_50);
      iStart = 1'b1;
      @(negedge iCLK_50);
      iStart = 1'b0;
    end
    wait_done(2000, lat, ok);
    iStart = 1'b1;
    @(negedge iCLK_50);
    iStart = 1'b0;
    chk("done_cycle_start_ignored", oBusy, 1'b0);
    repeat (100) @(negedge iCLK_50);
    chk("rep_done_pulses", dut_done_cnt - d0, 1);
    chk("rep_busy", oBusy, 1'b0);
    chk("rep_polls", m_polls, 4);
    chk("rep_s0", oString0, "repeat start L1 ");
    chk("rep_s1", oString1, "repeat start L2 ");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Counts cycles with oDone high
  int dut_done_cnt = 0;
  always @(posedge iCLK_50) begin
    if (oDone) dut_done_cnt <= dut_done_cnt + 1;
  end

endmodule
